// File: rtl/DH_pkg.sv
// Shared types and board-level constants for the game control logic.
// Pure definitions; no clocked logic lives here.
package DH_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    FIRE         = 3'd1,
    COOLDOWN     = 3'd2,
    DRY          = 3'd3,
    WAIT_RELEASE = 3'd4
  } trig_state_t;

  // 65 MHz board clock: 10 ms debounce, 250 ms re-fire cooldown.
  localparam int unsigned TRIG_DEBOUNCE_CYCLES   = 650_000;
  localparam int unsigned TRIG_COOLDOWN_CYCLES   = 16_250_000;
  localparam int unsigned TRIG_SHOT_PULSE_CYCLES = 4;

  localparam int unsigned TRIG_CTR_W = 8;

  function automatic logic [TRIG_CTR_W-1:0] sat_inc8(input logic [TRIG_CTR_W-1:0] v);
    return (v == {TRIG_CTR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ctl_debounce.sv
// Two-flop synchroniser plus counter debounce for a mechanical button input.
// dout follows din after 2 sync cycles plus DEBOUNCE_CYCLES steady cycles; no backpressure.
module ctl_debounce
  import DH_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = TRIG_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any sample agreeing with the stable value restarts the qualification window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/ctl_trigger.sv
// Trigger front-end: debounced press -> one shot pulse (or dry fire), cooldown, release-before-refire.
// shot_fired rises 3 + DEBOUNCE_CYCLES cycles after a clean press is first sampled; no backpressure.
module ctl_trigger
  import DH_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = TRIG_DEBOUNCE_CYCLES,
  parameter int unsigned COOLDOWN_CYCLES   = TRIG_COOLDOWN_CYCLES,
  parameter int unsigned SHOT_PULSE_CYCLES = TRIG_SHOT_PULSE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger_raw,
  input  logic       reset_score,
  input  logic       no_ammo,
  output logic       shot_fired,
  output logic       dry_fire,
  output logic       busy,
  output logic [7:0] fired_ctr
);

  localparam int unsigned TMR_MAX =
    (COOLDOWN_CYCLES > SHOT_PULSE_CYCLES) ? COOLDOWN_CYCLES : SHOT_PULSE_CYCLES;
  localparam int unsigned TW = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] PULSE_LAST = TW'(SHOT_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] COOL_LAST  = TW'(COOLDOWN_CYCLES - 1);

  logic                  stable;
  logic                  stable_prev_q;
  logic                  press_q;
  trig_state_t           state_q;
  logic [TW-1:0]         timer_q;
  logic                  shot_q;
  logic                  dry_q;
  logic                  busy_q;
  logic [TRIG_CTR_W-1:0] ctr_q;

  ctl_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (trigger_raw),
    .dout (stable)
  );

  // Registered rising-edge detect; the extra stage keeps every output a flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stable_prev_q <= 1'b0;
      press_q       <= 1'b0;
    end else begin
      stable_prev_q <= stable;
      press_q       <= stable & ~stable_prev_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      shot_q  <= 1'b0;
      dry_q   <= 1'b0;
      busy_q  <= 1'b0;
      ctr_q   <= '0;
    end else if (reset_score) begin
      // Parking in WAIT_RELEASE means a trigger held across a restart never fires.
      state_q <= WAIT_RELEASE;
      timer_q <= '0;
      shot_q  <= 1'b0;
      dry_q   <= 1'b0;
      busy_q  <= 1'b1;
      ctr_q   <= '0;
    end else begin
      dry_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (press_q) begin
            busy_q  <= 1'b1;
            timer_q <= '0;
            if (no_ammo) begin
              state_q <= DRY;
              dry_q   <= 1'b1;
            end else begin
              state_q <= FIRE;
              shot_q  <= 1'b1;
              ctr_q   <= sat_inc8(ctr_q);
            end
          end
        end
        FIRE: begin
          if (timer_q == PULSE_LAST) begin
            state_q <= COOLDOWN;
            shot_q  <= 1'b0;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        COOLDOWN: begin
          if (timer_q == COOL_LAST) begin
            state_q <= WAIT_RELEASE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DRY: begin
          state_q <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (!stable) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
          shot_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign shot_fired = shot_q;
  assign dry_fire   = dry_q;
  assign busy       = busy_q;
  assign fired_ctr  = ctr_q;

endmodule

// File: tb/tb_ctl_trigger.sv
// Bench for ctl_trigger: event-level reference model feeds expected pulses to a scoreboard;
// a negedge monitor pops and compares each shot/dry pulse and tracks busy and fired_ctr.
module tb_ctl_trigger;

  localparam int D = 4;
  localparam int C = 10;
  localparam int P = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       trigger_raw = 1'b0;
  logic       reset_score = 1'b0;
  logic       no_ammo = 1'b0;
  logic       shot_fired;
  logic       dry_fire;
  logic       busy;
  logic [7:0] fired_ctr;

  always #5 clk = ~clk;

  ctl_trigger #(
    .DEBOUNCE_CYCLES   (D),
    .COOLDOWN_CYCLES   (C),
    .SHOT_PULSE_CYCLES (P)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trigger_raw (trigger_raw),
    .reset_score (reset_score),
    .no_ammo     (no_ammo),
    .shot_fired  (shot_fired),
    .dry_fire    (dry_fire),
    .busy        (busy),
    .fired_ctr   (fired_ctr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int start;
    int width;
    int ctr;
  } ev_t;

  ev_t exp_shot_q[$];
  ev_t exp_dry_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (edge-indexed, timestamp based) ----------------
  int  cyc = 0;
  bit  m_hist0, m_hist1;        // raw samples from the previous two edges
  bit  m_stable;
  int  m_run;                   // consecutive edges where synced input differs from stable
  int  m_pend[$];               // edges at which a debounced press reaches the decision point
  bit  m_idle = 1'b1;
  int  m_wr;                    // edge after which the FSM waits for release
  bit  m_shot_act, m_dry_act;
  int  m_shot_start, m_shot_ctr, m_dry_start;
  int  m_ctr;
  bit  m_busy;

  task automatic close_shot();
    ev_t ev;
    ev.start = m_shot_start;
    ev.width = cyc - m_shot_start;
    ev.ctr   = m_shot_ctr;
    exp_shot_q.push_back(ev);
    m_shot_act = 1'b0;
  endtask

  task automatic close_dry();
    ev_t ev;
    ev.start = m_dry_start;
    ev.width = cyc - m_dry_start;
    ev.ctr   = m_ctr;
    exp_dry_q.push_back(ev);
    m_dry_act = 1'b0;
  endtask

  always @(posedge clk) begin : model
    bit old_stable;
    cyc++;
    if (!rst) begin
      if (m_shot_act) close_shot();
      if (m_dry_act) close_dry();
      m_hist0 = 0; m_hist1 = 0; m_stable = 0; m_run = 0;
      m_pend.delete();
      m_idle = 1; m_wr = 0; m_ctr = 0;
    end else begin
      old_stable = m_stable;
      if (m_shot_act && cyc == m_shot_start + P) close_shot();
      if (m_dry_act && cyc == m_dry_start + 1) close_dry();
      if (reset_score) begin
        if (m_shot_act) close_shot();
        m_ctr  = 0;
        m_idle = 0;
        m_wr   = cyc;
      end else if (m_idle) begin
        if (m_pend.size() > 0 && m_pend[0] == cyc) begin
          m_idle = 0;
          if (no_ammo) begin
            m_dry_act   = 1;
            m_dry_start = cyc;
            m_wr        = cyc + 1;
          end else begin
            m_ctr        = (m_ctr < 255) ? m_ctr + 1 : 255;
            m_shot_act   = 1;
            m_shot_start = cyc;
            m_shot_ctr   = m_ctr;
            m_wr         = cyc + P + C;
          end
        end
      end else if (cyc > m_wr && !old_stable) begin
        m_idle = 1;
      end
      while (m_pend.size() > 0 && m_pend[0] <= cyc) void'(m_pend.pop_front());
      if (m_hist1 != m_stable) begin
        m_run++;
        if (m_run == D) begin
          m_stable = !m_stable;
          m_run    = 0;
          if (m_stable) m_pend.push_back(cyc + 2);
        end
      end else begin
        m_run = 0;
      end
      m_hist1 = m_hist0;
      m_hist0 = trigger_raw;
    end
    m_busy = !m_idle;
  end

  // ---------------- monitor / scoreboard ----------------
  bit mon_en = 1'b0;
  bit prev_shot, prev_dry;
  int sh_start, sh_ctr, dr_start, dr_ctr;
  int n_shots = 0;
  int n_dry = 0;

  always @(negedge clk) begin : monitor
    ev_t ev;
    if (mon_en) begin
      check("busy", busy, m_busy);
      check("fired_ctr", fired_ctr, m_ctr);
      if (shot_fired && !prev_shot) begin
        sh_start = cyc; sh_ctr = fired_ctr; n_shots++;
      end
      if (!shot_fired && prev_shot) begin
        if (exp_shot_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL shot_unexpected: pulse at cycle %0d, expected none", sh_start);
        end else begin
          ev = exp_shot_q.pop_front();
          check("shot_start", sh_start, ev.start);
          check("shot_width", cyc - sh_start, ev.width);
          check("shot_ctr", sh_ctr, ev.ctr);
        end
      end
      if (dry_fire && !prev_dry) begin
        dr_start = cyc; dr_ctr = fired_ctr; n_dry++;
      end
      if (!dry_fire && prev_dry) begin
        if (exp_dry_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL dry_unexpected: pulse at cycle %0d, expected none", dr_start);
        end else begin
          ev = exp_dry_q.pop_front();
          check("dry_start", dr_start, ev.start);
          check("dry_width", cyc - dr_start, ev.width);
          check("dry_ctr", dr_ctr, ev.ctr);
        end
      end
      prev_shot = shot_fired;
      prev_dry  = dry_fire;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold, input int gap);
    trigger_raw = 1'b1;
    tick(hold);
    trigger_raw = 1'b0;
    tick(gap);
  endtask

  task automatic wait_rise(input string name, output int took);
    took = 0;
    while (!shot_fired && took < 60) begin
      tick(1);
      took++;
    end
    if (!shot_fired) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: shot_fired seen 0, expected rise within 60 cycles", name);
    end
  endtask

  initial begin : stim
    int t0, took, n0, d0, hold_start;

    // Reset state
    rst = 1'b0;
    tick(3);
    check("rst_shot", shot_fired, 0);
    check("rst_dry", dry_fire, 0);
    check("rst_busy", busy, 0);
    check("rst_ctr", fired_ctr, 0);
    rst = 1'b1;
    mon_en = 1'b1;
    tick(3);

    // Clean press held 40 cycles
    n0 = n_shots;
    trigger_raw = 1'b1;
    t0 = cyc + 1;
    wait_rise("clean_press", took);
    check("press_latency", cyc - t0, 3 + D);
    check("clean_ctr", fired_ctr, 1);
    tick(40 - took);
    trigger_raw = 1'b0;
    tick(30);
    check("clean_one_shot", n_shots - n0, 1);

    // Bounce, then held high
    n0 = n_shots;
    for (int i = 0; i < 5; i++) begin
      trigger_raw = 1'b1; tick(2);
      trigger_raw = 1'b0; tick(2);
    end
    trigger_raw = 1'b1;
    hold_start = cyc + 1;
    tick(30);
    trigger_raw = 1'b0;
    tick(30);
    check("bounce_one_shot", n_shots - n0, 1);
    check("bounce_shot_time", sh_start, hold_start + 3 + D);
    check("bounce_ctr", fired_ctr, 2);

    // Re-press during cooldown is ignored, later press fires
    n0 = n_shots;
    press(6, 5);
    press(6, 20);
    press(10, 30);
    check("cooldown_shots", n_shots - n0, 2);
    check("cooldown_ctr", fired_ctr, 4);

    // Dry fire
    n0 = n_shots; d0 = n_dry;
    no_ammo = 1'b1;
    press(10, 30);
    no_ammo = 1'b0;
    check("dry_count", n_dry - d0, 1);
    check("dry_no_shot", n_shots - n0, 0);
    check("dry_ctr_kept", fired_ctr, 4);

    // reset_score mid-FIRE with trigger held
    n0 = n_shots;
    trigger_raw = 1'b1;
    wait_rise("score_press", took);
    reset_score = 1'b1;
    tick(1);
    reset_score = 1'b0;
    check("score_shot_drop", shot_fired, 0);
    check("score_ctr_clear", fired_ctr, 0);
    tick(40);
    check("score_held_no_refire", n_shots - n0, 1);
    trigger_raw = 1'b0;
    tick(30);
    press(10, 30);
    check("score_fresh_press", n_shots - n0, 2);
    check("score_ctr_after", fired_ctr, 1);

    // Randomised traffic against the model
    for (int i = 0; i < 60; i++) begin
      trigger_raw = 1'($urandom_range(0, 1));
      no_ammo     = ($urandom_range(0, 4) == 0);
      reset_score = ($urandom_range(0, 14) == 0);
      tick(1);
      reset_score = 1'b0;
      tick($urandom_range(1, 25));
    end
    trigger_raw = 1'b0;
    no_ammo = 1'b0;
    tick(40);

    // Saturation after 260 presses
    reset_score = 1'b1;
    tick(1);
    reset_score = 1'b0;
    tick(5);
    n0 = n_shots;
    for (int i = 0; i < 260; i++) press(8, 20);
    check("sat_shots", n_shots - n0, 260);
    check("sat_ctr", fired_ctr, 255);

    // rst mid-cooldown
    n0 = n_shots;
    trigger_raw = 1'b1;
    wait_rise("rst_press", took);
    trigger_raw = 1'b0;
    tick(P + 2);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check("midrst_shot", shot_fired, 0);
    check("midrst_dry", dry_fire, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ctr", fired_ctr, 0);
    tick(30);
    check("midrst_no_shot", n_shots - n0, 1);

    check("shot_queue_left", exp_shot_q.size(), 0);
    check("dry_queue_left", exp_dry_q.size(), 0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
